decode_stage: RTL

- Registered, parametrised instruction-decode stage for the tetris350 CPU.
- Each accepted instruction word produces:
  - a one-hot opcode class vector;
  - an illegal-opcode flag;
  - extracted register, ALU-op and immediate/target fields.
- Sits between fetch and register-read.
- Uses a valid/ready handshake with an optional skid buffer, a pipeline flush, and a saturating illegal-opcode counter for debug.

---
 rtl/decode_stage.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered instruction-decode stage for the tetris350 CPU. It sits between
// fetch and register-read. Every accepted instruction word is decoded into a
// one-hot opcode class, an illegal-opcode flag and the raw instruction fields.
// The result is held in an output register until the consumer takes it.
//
// Handshake: a word moves on a side when valid and ready are both high at a
// rising clock edge (accept = in_valid & in_ready, deliver = out_valid &
// out_ready). A producer keeps valid and data stable until the word moves.
// While out_valid=1 and out_ready=0 every out_* signal holds its value.
//
// Parameters
//   INSN_W  instruction word width
//   OP_W    opcode / ALU-op field width
//   REG_W   register-specifier / shamt field width
//   DATA_W  width of the sign-extended immediate (>= IMM_W)
//   SKID    1: main + skid register, in_ready is a register decode
//           0: single register, in_ready = !out_valid | out_ready
//   CNT_W   illegal-opcode counter width
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   flush          synchronous; drops held words and any word accepted this cycle
//   in_valid/in_ready/in_insn         upstream handshake and instruction word
//   out_valid/out_ready               downstream handshake
//   out_class      one-hot class [0..13] = r, j, bne, jal, jr, addi, blt, sw,
//                  lw, isw, ilw, ri, setx, bex
//   out_illegal    opcode matches no class
//   out_rd/out_rs/out_rt/out_shamt    register and shamt fields
//   out_aluop      ALU-op field
//   out_imm        sign-extended immediate
//   out_target     zero-extended jump target field
//   illegal_count  saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int INSN_W = 32,
   parameter int OP_W   = 5,
   parameter int REG_W  = 5,
   parameter int DATA_W = 32,
   parameter int SKID   = 1,
   parameter int CNT_W  = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSN_W-1:0]         in_insn,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [13:0]               out_class,
   output logic                      out_illegal,
   output logic [REG_W-1:0]          out_rd,
   output logic [REG_W-1:0]          out_rs,
   output logic [REG_W-1:0]          out_rt,
   output logic [REG_W-1:0]          out_shamt,
   output logic [OP_W-1:0]           out_aluop,
   output logic [DATA_W-1:0]         out_imm,
   output logic [INSN_W-OP_W-1:0]    out_target,
   output logic [CNT_W-1:0]          illegal_count
);

   localparam int IMM_W = INSN_W - OP_W - 2*REG_W;
   localparam int TGT_W = INSN_W - OP_W;

   // Field positions, MSB first: opcode, rd, rs, rt, shamt, aluop.
   localparam int RD_HI    = INSN_W - OP_W - 1;
   localparam int RS_HI    = RD_HI - REG_W;
   localparam int RT_HI    = RS_HI - REG_W;
   localparam int SHAMT_HI = RT_HI - REG_W;
   localparam int ALUOP_HI = SHAMT_HI - REG_W;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Decoded payload, identical layout for the main and skid registers.
   typedef struct packed {
      logic [13:0]       cls;
      logic              illegal;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  shamt;
      logic [OP_W-1:0]   aluop;
      logic [DATA_W-1:0] imm;
      logic [TGT_W-1:0]  target;
   } dec_t;

   // Occupancy of the stage: nothing held, main register only, main + skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_e;

   occ_e              r_state;
   occ_e              w_state_nxt;
   dec_t              r_m;
   dec_t              r_s;
   dec_t              w_dec;
   logic [OP_W-1:0]   w_opcode;
   logic [31:0]       w_op_ext;
   logic              w_accept;
   logic              w_deliver;
   logic              w_load_m_in;
   logic              w_load_m_s;
   logic              w_load_s;
   logic [CNT_W-1:0]  r_illegal_count;

   // --------------------------------------------------------------------------
   // Combinational decode of the incoming word
   // --------------------------------------------------------------------------
   assign w_opcode = in_insn[INSN_W-1 -: OP_W];
   // Opcode compared as an unsigned number so class codes above 2^OP_W-1
   // simply never match on a narrow opcode.
   assign w_op_ext = 32'(w_opcode);

   always_comb begin
      w_dec = '0;
      case (w_op_ext)
         32'd0:   w_dec.cls[0]  = 1'b1;  // r
         32'd1:   w_dec.cls[1]  = 1'b1;  // j
         32'd2:   w_dec.cls[2]  = 1'b1;  // bne
         32'd3:   w_dec.cls[3]  = 1'b1;  // jal
         32'd4:   w_dec.cls[4]  = 1'b1;  // jr
         32'd5:   w_dec.cls[5]  = 1'b1;  // addi
         32'd6:   w_dec.cls[6]  = 1'b1;  // blt
         32'd7:   w_dec.cls[7]  = 1'b1;  // sw
         32'd8:   w_dec.cls[8]  = 1'b1;  // lw
         32'd9:   w_dec.cls[9]  = 1'b1;  // isw
         32'd10:  w_dec.cls[10] = 1'b1;  // ilw
         32'd11:  w_dec.cls[11] = 1'b1;  // ri
         32'd21:  w_dec.cls[12] = 1'b1;  // setx
         32'd22:  w_dec.cls[13] = 1'b1;  // bex
         default: w_dec.cls     = '0;
      endcase
      w_dec.illegal = ~|w_dec.cls;
      // Fields are extracted regardless of class.
      w_dec.rd      = in_insn[RD_HI -: REG_W];
      w_dec.rs      = in_insn[RS_HI -: REG_W];
      w_dec.rt      = in_insn[RT_HI -: REG_W];
      w_dec.shamt   = in_insn[SHAMT_HI -: REG_W];
      w_dec.aluop   = in_insn[ALUOP_HI -: OP_W];
      w_dec.imm     = DATA_W'($signed(in_insn[IMM_W-1:0]));
      w_dec.target  = in_insn[TGT_W-1:0];
   end

   // --------------------------------------------------------------------------
   // Handshake
   // --------------------------------------------------------------------------
   // With the skid buffer, ready depends only on the state register, so there
   // is no combinational path from out_ready back to in_ready.
   assign in_ready  = (SKID != 0) ? (r_state != ST_TWO)
                                  : ((r_state == ST_EMPTY) | out_ready);
   assign w_accept  = in_valid & in_ready;
   assign w_deliver = (r_state != ST_EMPTY) & out_ready;

   // --------------------------------------------------------------------------
   // Occupancy FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_m_in = 1'b0;
      w_load_m_s  = 1'b0;
      w_load_s    = 1'b0;
      if (flush) begin
         // Flush wins over everything, including a word accepted this cycle.
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_load_m_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_deliver) begin
                  if (w_accept) begin
                     w_load_m_in = 1'b1;
                  end else begin
                     w_state_nxt = ST_EMPTY;
                  end
               end else if (w_accept && (SKID != 0)) begin
                  // Main register is stalled: park the new word in the skid.
                  w_state_nxt = ST_TWO;
                  w_load_s    = 1'b1;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so no accept can coincide.
               if (w_deliver) begin
                  w_state_nxt = ST_ONE;
                  w_load_m_s  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Payload registers (stale contents after a flush are harmless)
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_m <= '0;
         r_s <= '0;
      end else begin
         if (w_load_m_in) begin
            r_m <= w_dec;
         end else if (w_load_m_s) begin
            r_m <= r_s;
         end
         if (w_load_s) begin
            r_s <= w_dec;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Illegal-opcode counter: counts accepted illegal words, saturates, and is
   // deliberately left alone by flush so debug history survives pipeline kills.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_illegal_count <= '0;
      end else if (w_accept && !flush && w_dec.illegal &&
                   (r_illegal_count != CNT_MAX)) begin
         r_illegal_count <= r_illegal_count + 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign out_valid     = (r_state != ST_EMPTY);
   assign out_class     = r_m.cls;
   assign out_illegal   = r_m.illegal;
   assign out_rd        = r_m.rd;
   assign out_rs        = r_m.rs;
   assign out_rt        = r_m.rt;
   assign out_shamt     = r_m.shamt;
   assign out_aluop     = r_m.aluop;
   assign out_imm       = r_m.imm;
   assign out_target    = r_m.target;
   assign illegal_count = r_illegal_count;

endmodule
